// File: rtl/lsu_stage.sv
// Load/store stage: accepts one op from execute, runs one memory access, retires via a one-cycle writeback pulse.
// Latency: non-memory ops retire 1 cycle after accept; loads retire 1 cycle after the response; stores 1 cycle after the request handshake.
// Backpressure: ex_ready is high only in IDLE; the request is held stable until mem_req_ready; WAIT gives up after RESP_TIMEOUT cycles.
//
// Ports: clk/reset_n (async active-low); ex_* execute handshake and operands; flush kills the in-flight op;
//        mem_req_* request channel; mem_resp_* response channel; wb_* retire pulse; bus_err/misalign_trap error pulses.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned loads/stores instead of aligning them down.
module lsu_stage #(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [63:0] ex_result,
    input  logic [63:0] ex_store_data,
    input  logic [6:0]  ex_opcode,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_we,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        bus_err,
    output logic        misalign_trap
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Counter only needs to reach RESP_TIMEOUT-1 (the last WAIT cycle).
    localparam int CW = (RESP_TIMEOUT < 3) ? 1 : $clog2(RESP_TIMEOUT);

    // Offset bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] f_low_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    logic [1:0]    r_state;
    logic          r_live;
    logic [63:0]   r_addr;
    logic [63:0]   r_sdata;
    logic [6:0]    r_opcode;
    logic [2:0]    r_funct3;
    logic [4:0]    r_rd;
    logic [63:0]   r_ldata;
    logic [CW-1:0] r_cnt;
    logic          r_kill;
    logic          r_err;

    logic          w_is_load;
    logic          w_is_store;
    logic [1:0]    w_size;
    logic [2:0]    w_off;
    logic [7:0]    w_size_mask;
    logic [63:0]   w_resp_sh;
    logic [63:0]   w_ld_ext;
    logic          w_accept;
    logic          w_ex_mem;
    logic          w_ex_mis;
    logic          w_mis;
    logic          w_in_req;
    logic          w_done;

    assign w_is_load  = (r_opcode == OP_LOAD);
    assign w_is_store = (r_opcode == OP_STORE);
    assign w_size     = r_funct3[1:0];
    // Align down to the access size; with trapping enabled misaligned ops never reach REQ, so this is a no-op there.
    assign w_off      = r_addr[2:0] & ~f_low_mask(w_size);
    assign w_resp_sh  = mem_resp_data >> {w_off, 3'b000};
    assign w_accept   = ex_valid && ex_ready && !flush;
    assign w_ex_mem   = (ex_opcode == OP_LOAD) || (ex_opcode == OP_STORE);
    assign w_in_req   = (r_state == S_REQ);
    assign w_done     = (r_state == S_DONE);

    always_comb begin
        w_size_mask = 8'hFF;
        case (w_size)
            2'd0:    w_size_mask = 8'h01;
            2'd1:    w_size_mask = 8'h03;
            2'd2:    w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
    end

    // funct3[2]=1 selects zero-extension (LBU/LHU/LWU).
    always_comb begin
        w_ld_ext = w_resp_sh;
        case (w_size)
            2'd0:    w_ld_ext = r_funct3[2] ? {56'd0, w_resp_sh[7:0]}
                                            : {{56{w_resp_sh[7]}}, w_resp_sh[7:0]};
            2'd1:    w_ld_ext = r_funct3[2] ? {48'd0, w_resp_sh[15:0]}
                                            : {{48{w_resp_sh[15]}}, w_resp_sh[15:0]};
            2'd2:    w_ld_ext = r_funct3[2] ? {32'd0, w_resp_sh[31:0]}
                                            : {{32{w_resp_sh[31]}}, w_resp_sh[31:0]};
            default: w_ld_ext = w_resp_sh;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_mis;
    assign w_ex_mis      = w_ex_mem && |(ex_result[2:0] & f_low_mask(ex_funct3[1:0]));
    assign w_mis         = r_mis;
    assign misalign_trap = w_done && r_mis;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mis <= 1'b0;
        end else if (w_accept) begin
            r_mis <= w_ex_mis;
        end
    end
`else
    assign w_ex_mis      = 1'b0;
    assign w_mis         = 1'b0;
    assign misalign_trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_live   <= 1'b0;
            r_addr   <= '0;
            r_sdata  <= '0;
            r_opcode <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_ldata  <= '0;
            r_cnt    <= '0;
            r_kill   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // Holds ex_ready low until the first edge after reset release.
            r_live <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= ex_result;
                        r_sdata  <= ex_store_data;
                        r_opcode <= ex_opcode;
                        r_funct3 <= ex_funct3;
                        r_rd     <= ex_rd;
                        r_kill   <= 1'b0;
                        r_err    <= 1'b0;
                        r_state  <= (w_ex_mem && !w_ex_mis) ? S_REQ : S_DONE;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        // Handshake already happened: the access must finish, only the retire is suppressed.
                        if (flush) r_kill <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= w_is_load ? S_WAIT : S_DONE;
                    end else if (flush) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (flush) r_kill <= 1'b1;
                    // A response on the timeout cycle takes priority.
                    if (mem_resp_valid) begin
                        r_ldata <= w_ld_ext;
                        r_state <= S_DONE;
                    end else if (r_cnt == CW'(RESP_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    // Flush here is handled combinationally on wb_we; the op leaves this cycle anyway.
                    r_kill  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ex_ready      = r_live && (r_state == S_IDLE);
    assign mem_req_valid = w_in_req;
    assign mem_req_addr  = w_in_req ? {r_addr[63:3], 3'b000} : 64'd0;
    assign mem_req_we    = w_in_req && w_is_store;
    assign mem_req_wdata = w_in_req ? (r_sdata << {w_off, 3'b000}) : 64'd0;
    assign mem_req_wstrb = w_in_req ? (w_size_mask << w_off) : 8'd0;

    assign wb_valid = w_done;
    assign wb_rd    = w_done ? r_rd : 5'd0;
    assign wb_data  = w_done ? (w_is_load ? r_ldata : r_addr) : 64'd0;
    assign wb_we    = w_done && !w_is_store && (r_opcode != OP_BRANCH) && (r_rd != 5'd0)
                      && !r_kill && !flush && !r_err && !w_mis;
    assign bus_err  = w_done && r_err;

endmodule

// File: tb/tb_lsu_stage.sv
module tb_lsu_stage;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADD   = 7'b0110011;

    logic        clk;
    logic        reset_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_result;
    logic [63:0] ex_store_data;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_we;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        bus_err;
    logic        misalign_trap;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_stage #(.RESP_TIMEOUT(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_opcode     (ex_opcode),
        .ex_funct3     (ex_funct3),
        .ex_rd         (ex_rd),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_we    (mem_req_we),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .bus_err       (bus_err),
        .misalign_trap (misalign_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] res,
                         input logic [63:0] sd, input logic [4:0] rd);
        ex_opcode     = op;
        ex_funct3     = f3;
        ex_result     = res;
        ex_store_data = sd;
        ex_rd         = rd;
        ex_valid      = 1'b1;
        tick();
        ex_valid      = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; ex_valid = 1'b0; ex_result = '0; ex_store_data = '0;
        ex_opcode = '0; ex_funct3 = '0; ex_rd = '0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

        // Reset values
        #12;
        chk("rst_ex_ready", 64'(ex_ready), 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_we", 64'(wb_we), 64'd0);
        chk("rst_wstrb", 64'(mem_req_wstrb), 64'd0);
        chk("rst_req_addr", mem_req_addr, 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_bus_err", 64'(bus_err), 64'd0);
        chk("rst_trap", 64'(misalign_trap), 64'd0);
        #6;
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready_low", 64'(ex_ready), 64'd0);
        tick();
        chk("post_rst_ready_high", 64'(ex_ready), 64'd1);

        // ADD: retires one cycle after accept, no memory traffic
        issue(OP_ADD, 3'b000, 64'h1234, 64'd0, 5'd5);
        chk("add_wb_valid", 64'(wb_valid), 64'd1);
        chk("add_wb_we", 64'(wb_we), 64'd1);
        chk("add_wb_rd", 64'(wb_rd), 64'd5);
        chk("add_wb_data", wb_data, 64'h1234);
        chk("add_no_req", 64'(mem_req_valid), 64'd0);
        chk("add_busy", 64'(ex_ready), 64'd0);
        tick();
        chk("add_pulse_end", 64'(wb_valid), 64'd0);
        chk("add_idle", 64'(ex_ready), 64'd1);

        // LB at 0x1003, sign-extended byte 3
        issue(OP_LOAD, 3'b000, 64'h1003, 64'd0, 5'd7);
        chk("lb_req_valid", 64'(mem_req_valid), 64'd1);
        chk("lb_req_addr", mem_req_addr, 64'h1000);
        chk("lb_req_we", 64'(mem_req_we), 64'd0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("lb_wait_no_req", 64'(mem_req_valid), 64'd0);
        mem_resp_valid = 1'b1; mem_resp_data = 64'h00000000_80000000;
        tick();
        mem_resp_valid = 1'b0;
        chk("lb_wb_valid", 64'(wb_valid), 64'd1);
        chk("lb_wb_we", 64'(wb_we), 64'd1);
        chk("lb_wb_data", wb_data, 64'hFFFFFFFF_FFFFFF80);
        tick();

        // LBU at the same address, zero-extended
        issue(OP_LOAD, 3'b100, 64'h1003, 64'd0, 5'd7);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 64'h00000000_80000000;
        tick();
        mem_resp_valid = 1'b0;
        chk("lbu_wb_data", wb_data, 64'h80);
        tick();

        // SH at 0x2006 with 3 cycles of request backpressure
        issue(OP_STORE, 3'b001, 64'h2006, 64'hBEEF, 5'd0);
        for (int i = 0; i < 4; i++) begin
            chk("sh_req_valid", 64'(mem_req_valid), 64'd1);
            chk("sh_req_addr", mem_req_addr, 64'h2000);
            chk("sh_req_we", 64'(mem_req_we), 64'd1);
            chk("sh_wstrb", 64'(mem_req_wstrb), 64'hC0);
            chk("sh_wdata", mem_req_wdata, 64'hBEEF0000_00000000);
            if (i == 3) mem_req_ready = 1'b1;
            tick();
        end
        mem_req_ready = 1'b0;
        chk("sh_wb_valid", 64'(wb_valid), 64'd1);
        chk("sh_wb_we", 64'(wb_we), 64'd0);
        tick();

        // LD timeout after 4 WAIT cycles
        issue(OP_LOAD, 3'b011, 64'h4000, 64'd0, 5'd9);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_no_wb", 64'(wb_valid), 64'd0);
            chk("to_wait_no_err", 64'(bus_err), 64'd0);
            tick();
        end
        chk("to_bus_err", 64'(bus_err), 64'd1);
        chk("to_wb_valid", 64'(wb_valid), 64'd1);
        chk("to_wb_we", 64'(wb_we), 64'd0);
        tick();
        chk("to_err_pulse_end", 64'(bus_err), 64'd0);

        // LD with the response on the timeout cycle: response wins
        issue(OP_LOAD, 3'b011, 64'h4000, 64'd0, 5'd9);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick(); tick(); tick();
        mem_resp_valid = 1'b1; mem_resp_data = 64'h11223344_55667788;
        tick();
        mem_resp_valid = 1'b0;
        chk("race_bus_err", 64'(bus_err), 64'd0);
        chk("race_wb_we", 64'(wb_we), 64'd1);
        chk("race_wb_data", wb_data, 64'h11223344_55667788);
        tick();

        // Flush in WAIT: the access completes but retires without write
        issue(OP_LOAD, 3'b010, 64'h5000, 64'd0, 5'd3);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 64'h1;
        tick();
        mem_resp_valid = 1'b0;
        chk("flw_wb_valid", 64'(wb_valid), 64'd1);
        chk("flw_wb_we", 64'(wb_we), 64'd0);
        tick();
        issue(OP_ADD, 3'b000, 64'h55, 64'd0, 5'd4);
        chk("flw_next_we", 64'(wb_we), 64'd1);
        chk("flw_next_data", wb_data, 64'h55);
        tick();

        // Flush with ex_valid in IDLE blocks the accept
        ex_opcode = OP_ADD; ex_rd = 5'd6; ex_valid = 1'b1; flush = 1'b1;
        tick();
        ex_valid = 1'b0; flush = 1'b0;
        chk("fli_ready", 64'(ex_ready), 64'd1);
        chk("fli_no_wb", 64'(wb_valid), 64'd0);

        // Flush in REQ before the handshake drops the op
        issue(OP_LOAD, 3'b010, 64'h5000, 64'd0, 5'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flr_ready", 64'(ex_ready), 64'd1);
        chk("flr_no_req", 64'(mem_req_valid), 64'd0);
        tick();
        chk("flr_no_wb", 64'(wb_valid), 64'd0);

        // Stray response in IDLE
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        chk("stray_no_wb", 64'(wb_valid), 64'd0);
        chk("stray_ready", 64'(ex_ready), 64'd1);

        // LW at 0x3002: trap or align down
        issue(OP_LOAD, 3'b010, 64'h3002, 64'd0, 5'd6);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_trap", 64'(misalign_trap), 64'd1);
        chk("mis_no_req", 64'(mem_req_valid), 64'd0);
        chk("mis_wb_valid", 64'(wb_valid), 64'd1);
        chk("mis_wb_we", 64'(wb_we), 64'd0);
        tick();
        chk("mis_trap_end", 64'(misalign_trap), 64'd0);
`else
        chk("mis_req_valid", 64'(mem_req_valid), 64'd1);
        chk("mis_req_addr", mem_req_addr, 64'h3000);
        chk("mis_trap_tied", 64'(misalign_trap), 64'd0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 64'h11223344_8899AABB;
        tick();
        mem_resp_valid = 1'b0;
        chk("mis_wb_data", wb_data, 64'hFFFFFFFF_8899AABB);
        chk("mis_wb_we", 64'(wb_we), 64'd1);
        tick();
`endif

        // Reset in WAIT abandons the access; a later response is ignored
        issue(OP_LOAD, 3'b011, 64'h6000, 64'd0, 5'd8);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rstw_ready", 64'(ex_ready), 64'd0);
        chk("rstw_no_wb", 64'(wb_valid), 64'd0);
        #1 reset_n = 1'b1;
        tick();
        chk("rstw_ready_back", 64'(ex_ready), 64'd1);
        mem_resp_valid = 1'b1; mem_resp_data = 64'hDEAD;
        tick();
        mem_resp_valid = 1'b0;
        chk("rstw_stray_no_wb", 64'(wb_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
